// File: rtl/l2_req_arb_pkg.sv
// l2_req_pkg: shared defaults, stream-id type and round-robin pointer wrap helper for l2_req_arb
package l2_req_pkg;
  localparam int NSTRMS = 64;
  localparam int MAX_OUTST = 8;
  typedef logic [$clog2(NSTRMS)-1:0] sid_t;
  function automatic int rr_next(input int s, input int n);
    return (s == n - 1) ? 0 : s + 1;
  endfunction
endpackage

// File: rtl/l2_req_arb_if.sv
// l2_req_arb_if: bundle of the L1 request/response, L2 read-command and L2 completion channels
//  slave  : the arbiter side (drives i_req_r, o_l2rd_*, i_l2done_r, o_rsp_v, o_outst)
//  master : the L1 / L2 side (drives i_req_v, o_l2rd_r, i_l2done_v/sid, o_rsp_r)
//  L2_REQ_ARB_PERF_EN adds o_perf_grants / o_perf_stall.
interface l2_req_arb_if import l2_req_pkg::*; #(
  parameter int nstrms = NSTRMS,
  parameter int max_outst = MAX_OUTST
);
  localparam int sid_width = $clog2(nstrms);
  localparam int cnt_width = $clog2(max_outst + 1);
  logic [nstrms-1:0] i_req_v;
  logic [nstrms-1:0] i_req_r;
  logic o_l2rd_v;
  logic o_l2rd_r;
  logic [sid_width-1:0] o_l2rd_sid;
  logic i_l2done_v;
  logic i_l2done_r;
  logic [sid_width-1:0] i_l2done_sid;
  logic [nstrms-1:0] o_rsp_v;
  logic [nstrms-1:0] o_rsp_r;
  logic [cnt_width-1:0] o_outst;
`ifdef L2_REQ_ARB_PERF_EN
  logic [31:0] o_perf_grants;
  logic [31:0] o_perf_stall;
`endif
  modport slave (
    input i_req_v, o_l2rd_r, i_l2done_v, i_l2done_sid, o_rsp_r,
    output i_req_r, o_l2rd_v, o_l2rd_sid, i_l2done_r, o_rsp_v, o_outst
`ifdef L2_REQ_ARB_PERF_EN
    , output o_perf_grants, o_perf_stall
`endif
  );
  modport master (
    output i_req_v, o_l2rd_r, i_l2done_v, i_l2done_sid, o_rsp_r,
    input i_req_r, o_l2rd_v, o_l2rd_sid, i_l2done_r, o_rsp_v, o_outst
`ifdef L2_REQ_ARB_PERF_EN
    , input o_perf_grants, o_perf_stall
`endif
  );
endinterface

// File: rtl/l2_req_arb_rr.sv
// l2_rr_arb: combinational round-robin priority arbiter
//  req : request vector        ptr : highest-priority index this cycle
//  gnt : one-hot winner        idx : encoded winner (0 when req is empty)
module l2_rr_arb #(
  parameter int n = 64,
  parameter int w = $clog2(n)
) (
  input  logic [n-1:0] req,
  input  logic [w-1:0] ptr,
  output logic [n-1:0] gnt,
  output logic [w-1:0] idx
);
  logic [n-1:0] hi;
  logic [n-1:0] sel;
  // Requests at or above ptr take priority; otherwise wrap to the lowest request.
  always_comb begin
    hi = req & ({n{1'b1}} << ptr);
    sel = (|hi) ? hi : req;
    gnt = sel & -sel;
    idx = '0;
    for (int i = 0; i < n; i++) if (gnt[i]) idx = w'(i);
  end
endmodule

// File: rtl/l2_req_arb.sv
// l2_req_arb: round-robin arbiter of per-stream L2 refill requests with in-flight tracking
//  clk, reset (async, active-high)
//  bus.slave : i_req_v/r (L1 requests), o_l2rd_v/r/sid (L2 read command),
//              i_l2done_v/r/sid (L2 completion), o_rsp_v/r (per-stream responses), o_outst
//  L2_REQ_ARB_PERF_EN: adds o_perf_grants and o_perf_stall counters on the bus.
module l2_req_arb import l2_req_pkg::*; #(
  parameter int nstrms = NSTRMS,
  parameter int max_outst = MAX_OUTST,
  parameter int sid_width = $clog2(nstrms),
  parameter int cnt_width = $clog2(max_outst + 1)
) (
  input logic clk,
  input logic reset,
  l2_req_arb_if.slave bus
);
  localparam logic [cnt_width-1:0] max_c = cnt_width'(max_outst);
  logic [nstrms-1:0] inflight_q, inflight_d, rsp_v_q, rsp_v_d, elig, gnt, req_r;
  logic [sid_width-1:0] ptr_q, ptr_d, sid_q, sid_d, idx;
  logic [cnt_width-1:0] outst_q, outst_d;
  logic l2rd_v_q, l2rd_v_d, grant, done_acc, done_ok;
  l2_rr_arb #(.n(nstrms), .w(sid_width)) u_rr (
    .req(elig),
    .ptr(ptr_q),
    .gnt(gnt),
    .idx(idx)
  );
  // A grant needs a free command register (empty or draining this cycle) and room under the cap.
  // A completion is only accepted when its stream has no response waiting; completions for
  // streams that are not in flight are swallowed without touching the count.
  always_comb begin
    elig = bus.i_req_v & ~inflight_q;
    req_r = ((~l2rd_v_q | bus.o_l2rd_r) && outst_q < max_c) ? gnt : '0;
    grant = |req_r;
    done_acc = bus.i_l2done_v & ~rsp_v_q[bus.i_l2done_sid];
    done_ok = done_acc & inflight_q[bus.i_l2done_sid];
    l2rd_v_d = grant | (l2rd_v_q & ~bus.o_l2rd_r);
    sid_d = grant ? idx : sid_q;
    ptr_d = grant ? sid_width'(rr_next(int'(idx), nstrms)) : ptr_q;
    inflight_d = (inflight_q & ~(rsp_v_q & bus.o_rsp_r)) | req_r;
    rsp_v_d = (rsp_v_q & ~bus.o_rsp_r) | (done_ok ? nstrms'(1) << bus.i_l2done_sid : '0);
    outst_d = outst_q + (grant ? cnt_width'(1) : '0) - (done_ok ? cnt_width'(1) : '0);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q <= '0;
      rsp_v_q <= '0;
      ptr_q <= '0;
      sid_q <= '0;
      outst_q <= '0;
      l2rd_v_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      rsp_v_q <= rsp_v_d;
      ptr_q <= ptr_d;
      sid_q <= sid_d;
      outst_q <= outst_d;
      l2rd_v_q <= l2rd_v_d;
    end
  end
  assign bus.i_req_r = req_r;
  assign bus.o_l2rd_v = l2rd_v_q;
  assign bus.o_l2rd_sid = sid_q;
  assign bus.i_l2done_r = ~rsp_v_q[bus.i_l2done_sid];
  assign bus.o_rsp_v = rsp_v_q;
  assign bus.o_outst = outst_q;
`ifdef L2_REQ_ARB_PERF_EN
  logic [31:0] grants_q, grants_d, stall_q, stall_d;
  // Stall: something is eligible but the cap or the command register blocks it.
  always_comb begin
    grants_d = grants_q + (grant ? 32'd1 : 32'd0);
    stall_d = stall_q + ((|elig && !grant) ? 32'd1 : 32'd0);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grants_q <= '0;
      stall_q <= '0;
    end else begin
      grants_q <= grants_d;
      stall_q <= stall_d;
    end
  end
  assign bus.o_perf_grants = grants_q;
  assign bus.o_perf_stall = stall_q;
`endif
  // A completion for a stream with nothing in flight is an upstream protocol error.
  assert property (@(posedge clk) disable iff (reset) done_acc |-> inflight_q[bus.i_l2done_sid]);
endmodule

// File: tb/tb_l2_req_arb.sv
// tb_l2_req_arb: vector table, directed corner sequences and a randomized model check for l2_req_arb
module tb_l2_req_arb;
  import l2_req_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  l2_req_arb_if #(.nstrms(64), .max_outst(8)) bus();
  l2_req_arb_if #(.nstrms(64), .max_outst(2)) bus2();
  l2_req_arb #(.nstrms(64), .max_outst(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  l2_req_arb #(.nstrms(64), .max_outst(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {
    bit rst;
    logic [63:0] req_v;
    logic l2rd_r;
    logic [63:0] req_r;
    logic l2rd_v;
    logic [5:0] sid;
    logic [3:0] outst;
  } vec_t;
  vec_t tv[11];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [63:0] b(input int i);
    return 64'd1 << i;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.i_req_v = '0; bus.o_l2rd_r = 1'b0; bus.i_l2done_v = 1'b0; bus.i_l2done_sid = '0; bus.o_rsp_r = '0;
    bus2.i_req_v = '0; bus2.o_l2rd_r = 1'b0; bus2.i_l2done_v = 1'b0; bus2.i_l2done_sid = '0; bus2.o_rsp_r = '0;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  logic [63:0] m_inf, m_pend, rv, rr, mix;
  logic [63:0] m3;
  int ptr, outst, cmd_sid, exp_g, dsid, di;
  bit cmd_v, lr, dv, dacc;
  int issued[$];
  initial begin
    m3 = b(3) | b(7) | b(60);
    mix = m3 | b(0) | b(62);
    tv[0]  = '{1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 6'd0, 4'd0};
    tv[1]  = '{1'b0, b(5), 1'b0, b(5), 1'b0, 6'd0, 4'd0};
    tv[2]  = '{1'b0, 64'd0, 1'b1, 64'd0, 1'b1, 6'd5, 4'd1};
    tv[3]  = '{1'b1, 64'd0, 1'b1, 64'd0, 1'b0, 6'd0, 4'd0};
    tv[4]  = '{1'b0, m3, 1'b1, b(3), 1'b0, 6'd0, 4'd0};
    tv[5]  = '{1'b0, m3, 1'b1, b(7), 1'b1, 6'd3, 4'd1};
    tv[6]  = '{1'b0, m3, 1'b1, b(60), 1'b1, 6'd7, 4'd2};
    tv[7]  = '{1'b0, mix, 1'b1, b(62), 1'b1, 6'd60, 4'd3};
    tv[8]  = '{1'b0, mix, 1'b1, b(0), 1'b1, 6'd62, 4'd4};
    tv[9]  = '{1'b0, mix, 1'b1, 64'd0, 1'b1, 6'd0, 4'd5};
    tv[10] = '{1'b0, 64'd0, 1'b1, 64'd0, 1'b0, 6'd0, 4'd5};
    idle();
    tick();
    tick();
    reset = 1'b0;
    chk("reset rsp_v", bus.o_rsp_v, 64'd0);
    foreach (tv[i]) begin
      reset = tv[i].rst;
      bus.i_req_v = tv[i].req_v;
      bus.o_l2rd_r = tv[i].l2rd_r;
      #1;
      chk($sformatf("tv%0d req_r", i), bus.i_req_r, tv[i].req_r);
      chk($sformatf("tv%0d l2rd_v", i), 64'(bus.o_l2rd_v), 64'(tv[i].l2rd_v));
      chk($sformatf("tv%0d l2rd_sid", i), 64'(bus.o_l2rd_sid), 64'(tv[i].sid));
      chk($sformatf("tv%0d outst", i), 64'(bus.o_outst), 64'(tv[i].outst));
      tick();
    end
    reset = 1'b0;
    // cap of two outstanding
    idle();
    do_reset();
    bus2.i_req_v = b(1) | b(2) | b(3) | b(4);
    bus2.o_l2rd_r = 1'b1;
    #1;
    chk("t3 grant1", bus2.i_req_r, b(1));
    tick();
    chk("t3 grant2", bus2.i_req_r, b(2));
    tick();
    chk("t3 capped req_r", bus2.i_req_r, 64'd0);
    chk("t3 outst at cap", 64'(bus2.o_outst), 64'd2);
    tick();
    bus2.i_l2done_v = 1'b1;
    bus2.i_l2done_sid = 6'd1;
    #1;
    chk("t3 done_r", 64'(bus2.i_l2done_r), 64'd1);
    chk("t3 cap holds with done", bus2.i_req_r, 64'd0);
    tick();
    bus2.i_l2done_v = 1'b0;
    #1;
    chk("t3 outst after done", 64'(bus2.o_outst), 64'd1);
    chk("t3 rsp_v", bus2.o_rsp_v, b(1));
    chk("t3 grant3", bus2.i_req_r, b(3));
    tick();
    chk("t3 sid3", 64'(bus2.o_l2rd_sid), 64'd3);
    chk("t3 outst final", 64'(bus2.o_outst), 64'd2);
    chk("t3 capped again", bus2.i_req_r, 64'd0);
`ifdef L2_REQ_ARB_PERF_EN
    chk("t3 perf_grants", bus2.o_perf_grants, 64'd3);
`endif
    // one in flight per stream, regrant after response
    idle();
    do_reset();
    bus.o_l2rd_r = 1'b1;
    bus.i_req_v = b(4);
    #1;
    chk("t4 grant", bus.i_req_r, b(4));
    tick();
    chk("t4 no second grant", bus.i_req_r, 64'd0);
    chk("t4 l2rd_v", 64'(bus.o_l2rd_v), 64'd1);
    chk("t4 sid", 64'(bus.o_l2rd_sid), 64'd4);
    tick();
    bus.i_l2done_v = 1'b1;
    bus.i_l2done_sid = 6'd4;
    #1;
    chk("t4 done_r", 64'(bus.i_l2done_r), 64'd1);
    tick();
    bus.i_l2done_v = 1'b0;
    #1;
    chk("t4 rsp_v set", bus.o_rsp_v, b(4));
    chk("t4 still blocked", bus.i_req_r, 64'd0);
    chk("t4 outst dec", 64'(bus.o_outst), 64'd0);
    bus.o_rsp_r = b(4);
    tick();
    bus.o_rsp_r = '0;
    #1;
    chk("t4 rsp_v clear", bus.o_rsp_v, 64'd0);
    chk("t4 regrant", bus.i_req_r, b(4));
    tick();
    chk("t4 regrant sid", 64'(bus.o_l2rd_sid), 64'd4);
    chk("t4 regrant outst", 64'(bus.o_outst), 64'd1);
    // completion backpressure and simultaneous grant+completion
    idle();
    do_reset();
    bus.o_l2rd_r = 1'b1;
    bus.i_req_v = b(9);
    #1;
    chk("t5 grant9", bus.i_req_r, b(9));
    tick();
    bus.i_req_v = '0;
    bus.i_l2done_v = 1'b1;
    bus.i_l2done_sid = 6'd9;
    #1;
    chk("t5 done_r first", 64'(bus.i_l2done_r), 64'd1);
    tick();
    chk("t5 done_r stall1", 64'(bus.i_l2done_r), 64'd0);
    tick();
    chk("t5 done_r stall2", 64'(bus.i_l2done_r), 64'd0);
    chk("t5 rsp_v", bus.o_rsp_v, b(9));
    chk("t5 outst", 64'(bus.o_outst), 64'd0);
    bus.i_l2done_v = 1'b0;
    bus.o_rsp_r = b(9);
    #1;
    chk("t5 done_r during rsp_r", 64'(bus.i_l2done_r), 64'd0);
    tick();
    bus.o_rsp_r = '0;
    #1;
    chk("t5 done_r released", 64'(bus.i_l2done_r), 64'd1);
    chk("t5 rsp_v clear", bus.o_rsp_v, 64'd0);
    bus.i_req_v = b(10);
    #1;
    chk("t5 grant10", bus.i_req_r, b(10));
    tick();
    bus.i_req_v = b(11);
    bus.i_l2done_v = 1'b1;
    bus.i_l2done_sid = 6'd10;
    #1;
    chk("t5 grant11", bus.i_req_r, b(11));
    chk("t5 outst before", 64'(bus.o_outst), 64'd1);
    tick();
    bus.i_req_v = '0;
    bus.i_l2done_v = 1'b0;
    #1;
    chk("t5 outst grant+done", 64'(bus.o_outst), 64'd1);
    chk("t5 sid11", 64'(bus.o_l2rd_sid), 64'd11);
    chk("t5 rsp10", bus.o_rsp_v, b(10));
    // asynchronous reset mid-operation
    idle();
    do_reset();
    bus.o_l2rd_r = 1'b1;
    bus.i_req_v = b(20) | b(21) | b(22);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t6 grant%0d", k), bus.i_req_r, b(20 + k));
      tick();
    end
    bus.o_l2rd_r = 1'b0;
    bus.i_req_v = '0;
    #1;
    chk("t6 outst 3", 64'(bus.o_outst), 64'd3);
    chk("t6 l2rd_v busy", 64'(bus.o_l2rd_v), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6 rst l2rd_v", 64'(bus.o_l2rd_v), 64'd0);
    chk("t6 rst sid", 64'(bus.o_l2rd_sid), 64'd0);
    chk("t6 rst outst", 64'(bus.o_outst), 64'd0);
    chk("t6 rst rsp_v", bus.o_rsp_v, 64'd0);
    chk("t6 rst req_r", bus.i_req_r, 64'd0);
    tick();
    reset = 1'b0;
    // randomized traffic against a queue-based model
    idle();
    do_reset();
    m_inf = '0; m_pend = '0; ptr = 0; outst = 0; cmd_v = 1'b0; cmd_sid = 0;
    issued.delete();
    for (int c = 0; c < 3000; c++) begin
      rv = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      lr = ($urandom_range(0, 9) < 7);
      rr = {$urandom, $urandom} & {$urandom, $urandom};
      dv = 1'b0;
      di = -1;
      dsid = $urandom_range(0, 63);
      if (issued.size() > 0 && $urandom_range(0, 2) == 0) begin
        di = $urandom_range(0, issued.size() - 1);
        dsid = issued[di];
        dv = 1'b1;
      end else if (m_pend != 0 && $urandom_range(0, 4) == 0) begin
        for (int k = 0; k < 64; k++) if (m_pend[(dsid + k) % 64]) begin
          dsid = (dsid + k) % 64;
          break;
        end
        dv = 1'b1;
      end
      bus.i_req_v = rv;
      bus.o_l2rd_r = lr;
      bus.o_rsp_r = rr;
      bus.i_l2done_v = dv;
      bus.i_l2done_sid = sid_t'(dsid);
      #1;
      exp_g = -1;
      if (outst < 8 && (!cmd_v || lr))
        for (int k = 0; k < 64; k++) if (rv[(ptr + k) % 64] && !m_inf[(ptr + k) % 64]) begin
          exp_g = (ptr + k) % 64;
          break;
        end
      chk("rnd req_r", bus.i_req_r, exp_g >= 0 ? b(exp_g) : 64'd0);
      chk("rnd l2rd_v", 64'(bus.o_l2rd_v), 64'(cmd_v));
      if (cmd_v) chk("rnd l2rd_sid", 64'(bus.o_l2rd_sid), 64'(cmd_sid));
      chk("rnd rsp_v", bus.o_rsp_v, m_pend);
      chk("rnd outst", 64'(bus.o_outst), 64'(outst));
      chk("rnd done_r", 64'(bus.i_l2done_r), 64'(!m_pend[dsid]));
      dacc = dv && !m_pend[dsid];
      if (cmd_v && lr) begin
        issued.push_back(cmd_sid);
        cmd_v = 1'b0;
      end
      m_inf = m_inf & ~(m_pend & rr);
      m_pend = m_pend & ~rr;
      if (dacc) begin
        m_pend[dsid] = 1'b1;
        outst--;
        issued.delete(di);
      end
      if (exp_g >= 0) begin
        m_inf[exp_g] = 1'b1;
        cmd_v = 1'b1;
        cmd_sid = exp_g;
        ptr = (exp_g + 1) % 64;
        outst++;
      end
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
